// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer
//
// Central stall/flush sequencer for the 5-stage MIPS pipeline. It combines
// four stall and flush sources into the pipeline-register enable, bubble and
// flush controls:
//   - load-use hazards between ID/EX and IF/ID
//   - a multi-cycle multiply occupying EX
//   - instruction-memory wait
//   - taken branches resolved in EX
// A two-state FSM (RUN / MUL_WAIT) with an 8-bit down-counter tracks how
// long the multiply occupies EX. While it does, the front end and EX stay
// frozen for the multiply's full latency.
//
// Parameters:
//   MUL_LAT  total multiply latency in cycles, counting the start cycle (2..255)
//   REG_W    register-specifier width
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset            asynchronous, active-high reset
//   id_ex_mem_read   instruction in EX is a load
//   id_ex_rt         load destination register
//   if_id_rs         rs of the instruction in ID
//   if_id_rt         rt of the instruction in ID
//   if_id_uses_rt    ID instruction reads rt as a source
//   ex_branch_taken  branch in EX resolved taken
//   ex_mul_start     multiply enters EX this cycle
//   imem_ready       instruction memory has valid data
//   pc_write         PC register enable
//   if_id_write      IF/ID register enable
//   if_id_flush      clear IF/ID to a NOP
//   id_ex_write      ID/EX register enable
//   id_ex_bubble     load a NOP into ID/EX
//   ex_mem_bubble    load a NOP into EX/MEM
//   mul_busy         multiply still occupying EX
//   mul_done         one-cycle pulse in the last multiply cycle
//   stall_cycles     saturating count of cycles with pc_write=0
//   flush_count      saturating count of taken-branch flushes
//
// Configuration macro:
//   STALL_STATS_EN   when defined, builds the two statistics counters. When
//                    undefined, stall_cycles and flush_count are tied to 0
//                    and no counter flops exist.

module pipeline_stall_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_mul_start,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  // The start cycle is spent in RUN, and the last MUL_WAIT cycle is mul_cnt==0.
  // So MUL_WAIT lasts MUL_LAT-1 cycles when mul_cnt is loaded with MUL_LAT-2.
  localparam logic [7:0] MUL_RELOAD = 8'(MUL_LAT - 2);

  state_t     state;
  state_t     next_state;
  logic [7:0] mul_cnt;
  logic [7:0] next_mul_cnt;
  logic       load_use;
  logic       branch_flush;

  // Load-use hazard: the load in EX writes a register that the instruction
  // in ID is about to read. Register 0 is never a real dependency.
  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rt != '0) &&
               ((id_ex_rt == if_id_rs) ||
                (if_id_uses_rt && (id_ex_rt == if_id_rt)));
  end

  // State register and multiply counter. Reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      mul_cnt <= 8'd0;
    end else begin
      state   <= next_state;
      mul_cnt <= next_mul_cnt;
    end
  end

  // Mealy control decode. Reset overrides everything: the front end is frozen
  // and a NOP is pushed into ID/EX so no stale instruction advances.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_busy      = 1'b0;
    mul_done      = 1'b0;
    branch_flush  = 1'b0;
    next_state    = state;
    next_mul_cnt  = mul_cnt;

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b1;
      next_state   = RUN;
      next_mul_cnt = 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            // Wrong-path instructions in IF/ID and ID are squashed. The PC
            // still loads, because it takes the branch target.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            branch_flush = 1'b1;
          end else if (!imem_ready || load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end

          // A multiply start that coincides with a taken branch is on the
          // wrong path, so it is dropped.
          if (ex_mul_start && !ex_branch_taken) begin
            next_state   = MUL_WAIT;
            next_mul_cnt = MUL_RELOAD;
          end
        end

        MUL_WAIT: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          mul_busy      = 1'b1;
          if (mul_cnt == 8'd0) begin
            mul_done   = 1'b1;
            next_state = RUN;
          end else begin
            next_mul_cnt = mul_cnt - 8'd1;
          end
        end

        default: begin
          next_state   = RUN;
          next_mul_cnt = 8'd0;
        end
      endcase
    end
  end

`ifdef STALL_STATS_EN
  // Statistics counters. Each counts a cycle on the edge that ends it and
  // sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (!pc_write && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (branch_flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`else
  assign stall_cycles = 16'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb_pipeline_stall_sequencer
//
// Directed testbench for pipeline_stall_sequencer with MUL_LAT=4 and REG_W=5.
// It applies hand-built vectors and compares the combinational controls in
// the middle of each cycle. Expected counter values come from a small
// cycle-by-cycle tally kept by the bench. With STALL_STATS_EN undefined,
// every expected counter value is 0.

module tb_pipeline_stall_sequencer;

  logic        clk;
  logic        reset;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic        if_id_uses_rt;
  logic        ex_branch_taken;
  logic        ex_mul_start;
  logic        imem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_bubble;
  logic        ex_mem_bubble;
  logic        mul_busy;
  logic        mul_done;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_stall_sequencer #(.MUL_LAT(4), .REG_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_rt        (id_ex_rt),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .if_id_uses_rt   (if_id_uses_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_mul_start    (ex_mul_start),
    .imem_ready      (imem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_bubble   (ex_mem_bubble),
    .mul_busy        (mul_busy),
    .mul_done        (mul_done),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrExp(input int v);
`ifdef STALL_STATS_EN
    return (v > 65535) ? 32'hFFFF : 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  task automatic applyStimulus(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt, input logic br,
                               input logic ms, input logic rdy);
    id_ex_mem_read  = mr;
    id_ex_rt        = ert;
    if_id_rs        = rs;
    if_id_rt        = rt;
    if_id_uses_rt   = urt;
    ex_branch_taken = br;
    ex_mul_start    = ms;
    imem_ready      = rdy;
  endtask

  // Advances one clock edge and tallies whether the cycle just ended should
  // have been counted as a stall and/or a flush.
  task automatic tick(input logic st, input logic fl);
    @(posedge clk);
    if (st) exp_stall++;
    if (fl) exp_flush++;
    #1;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cycles), ctrExp(exp_stall));
    checkOutput({tag, "_flush_count"}, 32'(flush_count), ctrExp(exp_flush));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    #12;
    // Reset forces the front end closed and pushes a bubble into ID/EX
    checkOutput("rst_pc_write", 32'(pc_write), 0);
    checkOutput("rst_if_id_write", 32'(if_id_write), 0);
    checkOutput("rst_id_ex_write", 32'(id_ex_write), 1);
    checkOutput("rst_id_ex_bubble", 32'(id_ex_bubble), 1);
    checkOutput("rst_mul_busy", 32'(mul_busy), 0);
    checkCounters("rst");
    tick(0, 0);
    reset = 1'b0;
    #3;
    checkOutput("idle_pc_write", 32'(pc_write), 1);
    checkOutput("idle_bubble", 32'(id_ex_bubble), 0);

    // Load-use on rs
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 1);
    #3;
    checkOutput("lu_pc_write", 32'(pc_write), 0);
    checkOutput("lu_if_id_write", 32'(if_id_write), 0);
    checkOutput("lu_bubble", 32'(id_ex_bubble), 1);
    checkOutput("lu_id_ex_write", 32'(id_ex_write), 1);
    tick(1, 0);
    applyStimulus(0, 5, 5, 0, 0, 0, 0, 1);
    #3;
    checkOutput("lu_after_pc_write", 32'(pc_write), 1);
    // Register 0 is never a dependency
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);
    #3;
    checkOutput("lu_r0_pc_write", 32'(pc_write), 1);
    tick(0, 0);

    // rt only counts when the ID instruction actually reads rt
    applyStimulus(1, 7, 3, 7, 0, 0, 0, 1);
    #3;
    checkOutput("rt_unused_pc_write", 32'(pc_write), 1);
    tick(0, 0);
    applyStimulus(1, 7, 3, 7, 1, 0, 0, 1);
    #3;
    checkOutput("rt_used_pc_write", 32'(pc_write), 0);
    checkOutput("rt_used_bubble", 32'(id_ex_bubble), 1);
    tick(1, 0);
    checkCounters("after_lu");

    // Branch beats imem wait and load-use
    applyStimulus(1, 7, 7, 0, 0, 1, 0, 0);
    #3;
    checkOutput("br_flush", 32'(if_id_flush), 1);
    checkOutput("br_bubble", 32'(id_ex_bubble), 1);
    checkOutput("br_pc_write", 32'(pc_write), 1);
    checkOutput("br_if_id_write", 32'(if_id_write), 1);
    tick(0, 1);
    checkCounters("after_br");

    // Instruction-memory wait alone
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("imem_pc_write", 32'(pc_write), 0);
    checkOutput("imem_bubble", 32'(id_ex_bubble), 1);
    tick(1, 0);

    // Multiply: start cycle plus 3 MUL_WAIT cycles; a branch in MUL_WAIT is ignored
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    #3;
    checkOutput("mul_start_pc_write", 32'(pc_write), 1);
    checkOutput("mul_start_busy", 32'(mul_busy), 0);
    tick(0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #3;
      checkOutput($sformatf("mul_w%0d_busy", i), 32'(mul_busy), 1);
      checkOutput($sformatf("mul_w%0d_done", i), 32'(mul_done), (i == 2) ? 1 : 0);
      checkOutput($sformatf("mul_w%0d_exmem_bubble", i), 32'(ex_mem_bubble), 1);
      checkOutput($sformatf("mul_w%0d_pc_write", i), 32'(pc_write), 0);
      checkOutput($sformatf("mul_w%0d_id_ex_write", i), 32'(id_ex_write), 0);
      checkOutput($sformatf("mul_w%0d_flush", i), 32'(if_id_flush), 0);
      tick(1, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("mul_end_busy", 32'(mul_busy), 0);
    checkOutput("mul_end_pc_write", 32'(pc_write), 1);
    checkCounters("after_mul");

    // Multiply start with a load-use hazard still stalls in the start cycle
    applyStimulus(1, 9, 9, 0, 0, 0, 1, 1);
    #3;
    checkOutput("mul_lu_pc_write", 32'(pc_write), 0);
    checkOutput("mul_lu_bubble", 32'(id_ex_bubble), 1);
    tick(1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("mul2_w0_busy", 32'(mul_busy), 1);
    tick(1, 0);
    #3;
    checkOutput("mul2_w1_busy", 32'(mul_busy), 1);
    checkOutput("mul2_w1_done", 32'(mul_done), 0);
    checkCounters("mul2_w1");

    // Reset in the 2nd MUL_WAIT cycle aborts the multiply
    reset = 1'b1;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    checkOutput("rstmul_pc_write", 32'(pc_write), 0);
    checkOutput("rstmul_busy", 32'(mul_busy), 0);
    checkOutput("rstmul_done", 32'(mul_done), 0);
    checkCounters("rstmul");
    tick(0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      checkOutput($sformatf("post_rst%0d_busy", i), 32'(mul_busy), 0);
      checkOutput($sformatf("post_rst%0d_done", i), 32'(mul_done), 0);
      checkOutput($sformatf("post_rst%0d_pc_write", i), 32'(pc_write), 1);
      tick(0, 0);
    end
    checkCounters("post_rst");

    // Saturation: 70000 stalled cycles overflow the 16-bit range
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      exp_stall++;
    end
    #1;
    checkCounters("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_sequencer.md
# pipeline_stall_sequencer

Central stall/flush sequencer for the 5-stage MIPS pipeline. Produces the pipeline-register write enables and bubble/flush controls from four sources:
- load-use hazards between ID/EX and IF/ID;
- a multi-cycle multiply in EX;
- instruction-memory wait;
- taken branches resolved in EX.

It also tracks multiply occupancy with a state machine and counter, so the front end and EX stay frozen for the multiply's full latency. It sits between the hazard comparators, the PC/IF/ID/EX pipeline registers and the multiplier.

## Interface
- MUL_LAT, 4, total multiply latency in cycles, counting the start cycle; legal range 2..255.
- REG_W, 5, register-specifier width.

- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  REG_W  load destination register.
- if_id_rs  in  REG_W  rs of the instruction in ID.
- if_id_rt  in  REG_W  rt of the instruction in ID.
- if_id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_branch_taken  in  1  branch in EX resolved taken.
- ex_mul_start  in  1  multiply enters EX this cycle.
- imem_ready  in  1  instruction memory has valid data.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID to a NOP.
- id_ex_write  out  1  ID/EX register enable.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- ex_mem_bubble  out  1  load a NOP into EX/MEM.
- mul_busy  out  1  high while the multiply is still occupying EX.
- mul_done  out  1  one-cycle pulse in the last multiply cycle.
- stall_cycles  out  16  saturating count of cycles with pc_write=0.
- flush_count  out  16  saturating count of taken-branch flushes.

## Operation
- Load-use hazard is defined as: id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==if_id_rs || (if_id_uses_rt && id_ex_rt==if_id_rt)).
- There are two states, RUN and MUL_WAIT, with an 8-bit down-counter mul_cnt.
- Controls are combinational (Mealy) from state and inputs. Defaults: pc_write=1, if_id_write=1, id_ex_write=1; all bubble and flush outputs 0.
- RUN, evaluated in priority order:
  1. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1 (the target is loaded); flush_count increments.
  2. Else !imem_ready: pc_write=0, if_id_write=0, id_ex_bubble=1.
  3. Else load-use hazard: pc_write=0, if_id_write=0, id_ex_bubble=1.
  4. Else the defaults apply.
- ex_mul_start in RUN with ex_branch_taken=0:
  - The start cycle itself behaves per the RUN rules above, so a load-use stall or !imem_ready stall still applies in that cycle.
  - Next state is MUL_WAIT, with mul_cnt loaded to MUL_LAT-2.
  - ex_mul_start together with ex_branch_taken is illegal; the branch wins and the start is ignored.
- MUL_WAIT:
  - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, mul_busy=1.
  - ex_branch_taken, ex_mul_start, imem_ready and the hazard inputs are ignored.
  - When mul_cnt==0: assert mul_done, and next state is RUN.
  - Otherwise mul_cnt decrements.
- While reset is high: state=RUN, mul_cnt=0, counters=0. Outputs are forced to pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1, all other outputs 0.
- Reset asserted mid-multiply aborts it; mul_done is not produced.

## Timing
- All control outputs are valid in the same cycle as the inputs that cause them; there is no added latency.
- A load-use stall lasts exactly one cycle per hazard, because the bubble removes the hazard in the next cycle.
- A multiply holds EX for MUL_LAT cycles in total: the start cycle plus MUL_LAT-1 cycles in MUL_WAIT.
- mul_done is high in the final MUL_WAIT cycle. RUN resumes on the following edge.
- With MUL_LAT=2, MUL_WAIT lasts one cycle, and mul_done is high in that cycle.
- Both counters update on the clock edge at the end of the counted cycle and saturate at 16'hFFFF.

## Configuration
- STALL_STATS_EN defined: stall_cycles and flush_count are implemented as described.
- STALL_STATS_EN undefined: both ports are present and tied to 0, and no counter flops are built.
- All other behaviour is identical in both cases.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. With id_ex_rt=0 -> no stall.
- rt gating: id_ex_rt=7, if_id_rt=7, if_id_uses_rt=0 -> no stall. With if_id_uses_rt=1 -> stall.
- Branch priority: ex_branch_taken=1 together with a load-use hazard and imem_ready=0 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count increments by 1.
- Multiply, MUL_LAT=4: ex_mul_start pulse -> mul_busy=1 for 3 cycles, with mul_done in the third and ex_mem_bubble=1 throughout. A branch asserted during MUL_WAIT is ignored.
- Reset mid-multiply: reset asserted in the 2nd MUL_WAIT cycle -> immediate RUN on release, no mul_done, counters=0, pc_write=0 while reset is high.
- Saturation (STALL_STATS_EN defined): hold imem_ready=0 for 70000 cycles -> stall_cycles=16'hFFFF. With the macro undefined -> stall_cycles stays 0.
